// File: rtl/mips_if_pkg.sv
// Shared fetch-path types and default geometry for the MIPS instruction-fetch block.
package mips_if_pkg;

   localparam logic [31:0] PC_BASE  = 32'h0000_3000;
   localparam int          IM_WORDS = 1024;
   localparam int          FQ_DEPTH = 2;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-controller bus: IM address/data, redirect request and IF/ID head handshake.
interface if_fetch_ctrl_if;

   logic [31:0] im_addr;
   logic [31:0] im_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        fault;

   modport master (
      output im_addr,
      input  im_data,
      input  redirect_valid,
      input  redirect_pc,
      input  id_ready,
      output inst_valid,
      output inst,
      output inst_pc,
      output fault
   );

   modport slave (
      input  im_addr,
      output im_data,
      output redirect_valid,
      output redirect_pc,
      output id_ready,
      input  inst_valid,
      input  inst,
      input  inst_pc,
      input  fault
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two queue of fetched {pc, inst} entries; head reads as zero when empty.
module fetch_fifo
   import mips_if_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  fetch_entry_t             wdata_i,
   output fetch_entry_t             head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o
);

   localparam int             PW       = $clog2(DEPTH);
   localparam logic [PW:0]    FULL_CNT = DEPTH[PW:0];

   fetch_entry_t    mem_q [DEPTH];
   logic [PW-1:0]   rd_q, wr_q;
   logic [PW:0]     cnt_q;
   logic            empty;
   logic            do_pop, do_push;

   assign empty   = (cnt_q == '0);
   assign full_o  = (cnt_q == FULL_CNT);
   assign count_o = cnt_q;
   assign do_pop  = pop_i && !empty && !flush_i;
   assign do_push = push_i && (!full_o || do_pop) && !flush_i;
   assign head_o  = empty ? '0 : mem_q[rd_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, range-checks it, and queues fetched words for decode.
module if_fetch_ctrl
   import mips_if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = PC_BASE,
   parameter int          IM_DEPTH = IM_WORDS,
   parameter int          QDEPTH   = FQ_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   if_fetch_ctrl_if.master   bus
);

   localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * (IM_DEPTH - 1));

   fetch_state_e                state_q, state_d;
   logic [31:0]                 pc_q, pc_d;
   logic                        pc_ok;
   logic                        fetch_en, push, pop;
   logic                        fault_o;
   logic                        q_full;
   logic [$clog2(QDEPTH):0]     q_cnt;
   fetch_entry_t                q_head, q_wdata;

   assign pc_ok = (pc_q[1:0] == 2'b00) && (pc_q >= RESET_PC) && (pc_q <= LAST_PC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.redirect_valid)              state_d = RUN;
      else if (state_q == RUN && !pc_ok)   state_d = FAULT;
   end

   always_comb begin
      fetch_en = (state_q == RUN) && !bus.redirect_valid && pc_ok;
      fault_o  = (state_q == FAULT);
   end

   // A same-cycle pop frees the slot, so a full queue can still accept a fetch.
   assign pop  = bus.inst_valid && bus.id_ready && !bus.redirect_valid;
   assign push = fetch_en && (!q_full || pop);

   always_comb begin
      pc_d = pc_q;
      if (bus.redirect_valid) pc_d = bus.redirect_pc;
      else if (push)          pc_d = pc_q + 32'd4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign q_wdata = '{pc: pc_q, inst: bus.im_data};

   fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (bus.redirect_valid),
      .wdata_i (q_wdata),
      .head_o  (q_head),
      .count_o (q_cnt),
      .full_o  (q_full)
   );

   assign bus.im_addr    = pc_q;
   assign bus.inst_valid = (q_cnt != '0);
   assign bus.inst       = q_head.inst;
   assign bus.inst_pc    = q_head.pc;
   assign bus.fault      = fault_o;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a combinational IM model of incrementing words.
module tb_if_fetch_ctrl;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   logic [31:0] im_mem [1024];
   logic [31:0] im_off;

   if_fetch_ctrl_if bus_if ();

   if_fetch_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      im_off = bus_if.im_addr - 32'h0000_3000;
      bus_if.im_data = (im_off < 32'h0000_1000) ? im_mem[im_off[11:2]] : 32'hDEAD_BEEF;
   end

   function automatic logic [31:0] exp_inst(input logic [31:0] pc);
      return 32'h2008_0001 + ((pc - 32'h0000_3000) >> 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_release();
      rst_n = 1'b0;
      bus_if.redirect_valid = 1'b0;
      bus_if.redirect_pc    = '0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic redirect(input logic [31:0] tgt);
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = tgt;
      step();
      bus_if.redirect_valid = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 1024; i++) im_mem[i] = 32'h2008_0001 + i;
      rst_n = 1'b0;
      bus_if.redirect_valid = 1'b0;
      bus_if.redirect_pc    = '0;
      bus_if.id_ready       = 1'b1;
      #12;
      chk("rst_valid", 32'(bus_if.inst_valid), 32'd0);
      chk("rst_inst", bus_if.inst, 32'd0);
      chk("rst_pc", bus_if.inst_pc, 32'd0);
      chk("rst_fault", 32'(bus_if.fault), 32'd0);
      chk("rst_imaddr", bus_if.im_addr, 32'h3000);

      // streaming fetch, one per cycle
      reset_release();
      for (int i = 0; i < 4; i++) begin
         step();
         chk("seq_valid", 32'(bus_if.inst_valid), 32'd1);
         chk("seq_pc", bus_if.inst_pc, 32'h3000 + 32'(4 * i));
         chk("seq_inst", bus_if.inst, exp_inst(32'h3000 + 32'(4 * i)));
      end

      // decode stall fills the queue and freezes the PC
      bus_if.id_ready = 1'b0;
      reset_release();
      for (int i = 0; i < 5; i++) step();
      chk("stall_imaddr", bus_if.im_addr, 32'h3008);
      chk("stall_valid", 32'(bus_if.inst_valid), 32'd1);
      chk("stall_pc", bus_if.inst_pc, 32'h3000);
      chk("stall_inst", bus_if.inst, 32'h2008_0001);
      bus_if.id_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         step();
         chk("drain_pc", bus_if.inst_pc, 32'h3000 + 32'(4 * i));
         chk("drain_inst", bus_if.inst, exp_inst(32'h3000 + 32'(4 * i)));
      end

      // redirect while full: one bubble, then the target word
      bus_if.id_ready = 1'b0;
      reset_release();
      step();
      step();
      bus_if.id_ready = 1'b1;
      redirect(32'h3100);
      chk("redir_valid", 32'(bus_if.inst_valid), 32'd0);
      chk("redir_imaddr", bus_if.im_addr, 32'h3100);
      step();
      chk("redir_tvalid", 32'(bus_if.inst_valid), 32'd1);
      chk("redir_tpc", bus_if.inst_pc, 32'h3100);
      chk("redir_tinst", bus_if.inst, 32'h2008_0041);

      // misaligned target faults and stays frozen until redirected
      redirect(32'h3002);
      chk("mis_valid0", 32'(bus_if.inst_valid), 32'd0);
      chk("mis_fault0", 32'(bus_if.fault), 32'd0);
      step();
      chk("mis_fault1", 32'(bus_if.fault), 32'd1);
      chk("mis_valid1", 32'(bus_if.inst_valid), 32'd0);
      step();
      chk("mis_sticky", 32'(bus_if.fault), 32'd1);
      chk("mis_frozen", bus_if.im_addr, 32'h3002);
      redirect(32'h3000);
      chk("recov_fault", 32'(bus_if.fault), 32'd0);
      chk("recov_valid0", 32'(bus_if.inst_valid), 32'd0);
      step();
      chk("recov_pc", bus_if.inst_pc, 32'h3000);
      chk("recov_inst", bus_if.inst, 32'h2008_0001);

      // run off the top of IM
      redirect(32'h3FF0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("top_valid", 32'(bus_if.inst_valid), 32'd1);
         chk("top_pc", bus_if.inst_pc, 32'h3FF0 + 32'(4 * i));
         chk("top_inst", bus_if.inst, exp_inst(32'h3FF0 + 32'(4 * i)));
      end
      step();
      chk("top_fault", 32'(bus_if.fault), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("top_novalid", 32'(bus_if.inst_valid), 32'd0);
         step();
      end

      // asynchronous reset between edges
      redirect(32'h3000);
      step();
      step();
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus_if.inst_valid), 32'd0);
      chk("arst_inst", bus_if.inst, 32'd0);
      chk("arst_pc", bus_if.inst_pc, 32'd0);
      chk("arst_fault", 32'(bus_if.fault), 32'd0);
      chk("arst_imaddr", bus_if.im_addr, 32'h3000);
      step();
      rst_n = 1'b1;
      step();
      chk("arst_first_valid", 32'(bus_if.inst_valid), 32'd1);
      chk("arst_first_pc", bus_if.inst_pc, 32'h3000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
